// File: rtl/adder_tree_int_pipe_if.sv
// Beat-in / result-out handshake bundle for adder_tree_int_pipe.
// DW_OUT must match the width the block derives for its result.
interface adder_tree_int_pipe_if #(
    parameter int unsigned NUM_IN  = 8,
    parameter int unsigned DW_DATA = 16,
    parameter int unsigned DW_OUT  = 19
);
    logic                            in_valid;
    logic                            in_ready;
    logic [NUM_IN*DW_DATA-1:0]       in_data;
    logic                            in_last;
    logic                            out_valid;
    logic                            out_ready;
    logic signed [DW_OUT-1:0]        out_data;
    logic                            out_last;
    logic                            busy;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/adder_tree_int_pipe.sv
// Pipelined signed adder tree, one register per tree level, global stall enable.
// Define ADDER_TREE_ACC_EN to add a group accumulator stage after the tree.
module adder_tree_int_pipe #(
    parameter int unsigned NUM_IN  = 8,
    parameter int unsigned DW_DATA = 16,
    parameter int unsigned DW_ACC  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    adder_tree_int_pipe_if.slave bus
);
    localparam int unsigned LVL    = $clog2(NUM_IN);
    localparam int unsigned DW_SUM = DW_DATA + LVL;
`ifdef ADDER_TREE_ACC_EN
    localparam int unsigned DW_OUT = DW_SUM + DW_ACC;
`else
    localparam int unsigned DW_OUT = DW_SUM;
`endif

    if (NUM_IN < 2 || NUM_IN > 64 || (NUM_IN & (NUM_IN - 1)) != 0) begin : g_bad_num_in
        $error("adder_tree_int_pipe: NUM_IN must be a power of two in 2..64");
    end
    if (DW_DATA < 2 || DW_DATA + LVL + DW_ACC > 64) begin : g_bad_width
        $error("adder_tree_int_pipe: DW_DATA/DW_ACC out of range");
    end

    logic           en;
    logic           accept;
    logic [LVL-1:0] vld_q;
    logic [LVL-1:0] lst_q;

    assign en          = !bus.out_valid || bus.out_ready;
    assign accept      = bus.in_valid && en;
    assign bus.in_ready = en;

    // Valid/last side-band travels with the partial sums, bubble on no accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            lst_q <= '0;
        end else if (en) begin
            vld_q <= (vld_q << 1) | LVL'(accept);
            lst_q <= (lst_q << 1) | LVL'(accept && bus.in_last);
        end
    end

    // Level k holds NUM_IN>>k partial sums, each one bit wider than level k-1
    for (genvar k = 0; k <= LVL; k++) begin : g_lvl
        localparam int unsigned N = NUM_IN >> k;
        localparam int unsigned W = DW_DATA + k;
        logic signed [W-1:0] sum [N];

        if (k == 0) begin : g_in
            for (genvar i = 0; i < N; i++) begin : g_lane
                assign sum[i] = bus.in_data[DW_DATA*i +: DW_DATA];
            end
        end else begin : g_add
            for (genvar i = 0; i < N; i++) begin : g_node
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        sum[i] <= '0;
                    end else if (en) begin
                        sum[i] <= W'(g_lvl[k-1].sum[2*i]) + W'(g_lvl[k-1].sum[2*i+1]);
                    end
                end
            end
        end
    end

`ifdef ADDER_TREE_ACC_EN
    logic                     open_q;
    logic                     out_valid_q;
    logic                     out_last_q;
    logic signed [DW_OUT-1:0] acc_q;
    logic signed [DW_OUT-1:0] out_data_q;
    logic signed [DW_OUT-1:0] sum_ext_c;
    logic signed [DW_OUT-1:0] base_c;
    logic signed [DW_OUT-1:0] total_c;

    // A closed group restarts from zero so its first beat loads the sum
    assign sum_ext_c = DW_OUT'(g_lvl[LVL].sum[0]);
    assign base_c    = open_q ? acc_q : '0;
    assign total_c   = base_c + sum_ext_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            open_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            acc_q       <= '0;
            out_data_q  <= '0;
        end else if (en) begin
            out_valid_q <= vld_q[LVL-1] && lst_q[LVL-1];
            if (vld_q[LVL-1]) begin
                if (lst_q[LVL-1]) begin
                    out_data_q <= total_c;
                    out_last_q <= 1'b1;
                    acc_q      <= '0;
                    open_q     <= 1'b0;
                end else begin
                    acc_q  <= total_c;
                    open_q <= 1'b1;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = (|vld_q) || out_valid_q || open_q;
`else
    assign bus.out_valid = vld_q[LVL-1];
    assign bus.out_last  = lst_q[LVL-1];
    assign bus.out_data  = DW_OUT'(g_lvl[LVL].sum[0]);
    assign bus.busy      = |vld_q;
`endif

endmodule

// File: doc/adder_tree_int_pipe.md
ADDER_TREE_INT_PIPE -- requirements
Module: adder_tree_int_pipe

Interface
REQ-001 SHALL have parameter NUM_IN, default 8, number of input lanes; power of two, 2..64.
REQ-002 SHALL have parameter DW_DATA, default 16, width of each signed input lane.
REQ-003 SHALL have parameter DW_ACC, default 8, extra accumulator guard bits, used only with ADDER_TREE_ACC_EN.
REQ-004 SHALL derive localparams LVL = log2(NUM_IN), DW_SUM = DW_DATA+LVL, DW_OUT = DW_SUM+DW_ACC with ADDER_TREE_ACC_EN, else DW_SUM.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-007 SHALL have port in_valid  input  1  input beat valid.
REQ-008 SHALL have port in_ready  output  1  block accepts beat this cycle.
REQ-009 SHALL have port in_data  input  NUM_IN*DW_DATA  signed lanes, lane i at bits [DW_DATA*i +: DW_DATA].
REQ-010 SHALL have port in_last  input  1  last beat of an accumulation group.
REQ-011 SHALL have port out_valid  output  1  result valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts result.
REQ-013 SHALL have port out_data  output  DW_OUT  signed result.
REQ-014 SHALL have port out_last  output  1  in_last carried alongside result.
REQ-015 SHALL have port busy  output  1  high while any pipeline stage or accumulator holds valid data.

Function
REQ-016 SHALL sign-extend lanes and add them in a binary tree of LVL levels, each level registered, exact (no overflow) at DW_SUM bits.
REQ-017 SHALL carry a valid bit and last bit per tree level alongside the partial sums.
REQ-018 SHALL use a global pipeline enable en = !out_valid | out_ready; all stage registers, valid and last bits advance only when en=1.
REQ-019 SHALL drive in_ready = en; a beat is accepted when in_valid & in_ready.
REQ-020 SHALL insert a bubble (valid=0) at level 1 when en=1 and no beat is accepted.
REQ-021 SHALL hold all stage contents and out_data/out_valid/out_last stable while out_valid=1 and out_ready=0.
REQ-022 Without ADDER_TREE_ACC_EN, SHALL present each accepted beat's sum on out_data with out_valid rising exactly LVL cycles after acceptance under continuous out_ready=1; one output per input beat, out_last = that beat's in_last.
REQ-023 With ADDER_TREE_ACC_EN, SHALL add an accumulator stage after the tree: a first beat of a group loads acc = sign-extended sum, subsequent beats do acc = acc + sum, modulo 2^DW_OUT (wrap, no saturation).
REQ-024 With ADDER_TREE_ACC_EN, SHALL emit one result per group: on the in_last beat, out_data = acc + sum, out_valid=1, out_last=1, exactly LVL+1 cycles after acceptance of that beat under out_ready=1; non-last beats produce no output.
REQ-025 With ADDER_TREE_ACC_EN, SHALL treat the beat following an emitted result as the first beat of a new group; a group of one beat (in_last on first beat) outputs its own sum.
REQ-026 SHALL sustain one accepted beat per cycle when out_ready=1 continuously.
REQ-027 SHALL drive busy = OR of all stage valid bits, out_valid, and (with ADDER_TREE_ACC_EN) an open-group flag.

Reset
REQ-028 SHALL clear on rst all stage valid/last bits, partial sums, accumulator, open-group flag, out_valid=0, out_data=0, out_last=0, busy=0; in_ready=1 during and after reset.
REQ-029 SHALL discard in-flight beats and any partially accumulated group when rst asserts mid-operation; first beat after release starts a new group.

Configuration
REQ-030 SHALL compile the accumulator stage (REQ-023..025) only when macro ADDER_TREE_ACC_EN is defined; without it DW_ACC is unused, latency is LVL, and no accumulator logic exists.

Verification
REQ-031 NUM_IN=8, DW_DATA=16, no macro: lanes 1..8, out_ready=1 -> out_data=36 exactly 3 cycles after acceptance.
REQ-032 All lanes -32768 (NUM_IN=8) -> out_data=-262144 at DW_SUM=19 bits, no overflow.
REQ-033 Macro on: three beats all lanes 1, in_last on third -> single output 24, out_last=1, 4 cycles after third beat; no output for beats 1-2.
REQ-034 Back-to-back stream, out_ready low for 5 cycles mid-stream -> in_ready low, out_data held stable, no beat lost or duplicated, order preserved.
REQ-035 Macro on, DW_ACC=0... replaced by DW_ACC=1, repeated max-positive groups -> accumulator wraps modulo 2^DW_OUT per REQ-023.
REQ-036 rst pulse while 2 beats in flight and a group open -> out_valid=0, busy=0 next cycle; next group result excludes pre-reset beats.
